// File: rtl/xp_award_engine.sv
// -----------------------------------------------------------------------------
// xp_award_engine
// Multi-slot XP award engine. Holds XP and level for every party slot. It takes
// one award per faint event over a valid/ready handshake. The engine computes
// species yield x foe level, then applies each earned level-up, one per cycle,
// and keeps the carry-over remainder.
//
// Ports
//   Clk, Reset_n     rising-edge clock, async active-low reset
//   award_valid      award request present
//   award_ready      engine idle; accepted when valid & ready at a rising edge
//   award_slot       slot receiving XP (>= NUM_SLOTS: completes, writes nothing)
//   foe_id           defeated species id (5-bit sprite id)
//   foe_level        defeated foe level
//   rd_slot          read-port slot select
//   rd_xp, rd_level  stored XP / level of rd_slot (combinational read)
//   level_up         one-cycle pulse per level gained
//   level_up_slot    slot of the current level_up pulse
//   done             one-cycle pulse after slot write-back
//   busy             ~award_ready
// -----------------------------------------------------------------------------
module xp_award_engine #(
    parameter  int NUM_SLOTS  = 6,
    parameter  int XP_W       = 8,
    parameter  int LVL_W      = 4,
    parameter  int XP_THRESH  = 256,
    parameter  int MAX_LEVEL  = 15,
    parameter  int INIT_LEVEL = 1,
    localparam int SLOT_W     = $clog2(NUM_SLOTS)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              award_valid,
    output logic              award_ready,
    input  logic [SLOT_W-1:0] award_slot,
    input  logic [4:0]        foe_id,
    input  logic [LVL_W-1:0]  foe_level,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic [XP_W-1:0]   rd_xp,
    output logic [LVL_W-1:0]  rd_level,
    output logic              level_up,
    output logic [SLOT_W-1:0] level_up_slot,
    output logic              done,
    output logic              busy
);

    localparam int GAIN_W = 8 + LVL_W;
    localparam int ACC_W  = XP_W + LVL_W + 9;

    localparam logic [SLOT_W:0]  NUM_SLOTS_L = NUM_SLOTS[SLOT_W:0];
    localparam logic [ACC_W-1:0] THRESH_A    = ACC_W'(XP_THRESH);
    localparam logic [ACC_W-1:0] SAT_A       = ACC_W'(XP_THRESH - 1);
    localparam logic [LVL_W-1:0] MAX_L       = LVL_W'(MAX_LEVEL);
    localparam logic [LVL_W-1:0] INIT_L      = LVL_W'(INIT_LEVEL);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_ADD,
        ST_LVL,
        ST_COMMIT
    } state_e;

    // Species yield table; unknown ids award the base yield of 10.
    function automatic logic [7:0] yield_of(input logic [4:0] id);
        case (id)
            5'b01100: yield_of = 8'd25;
            5'b01101: yield_of = 8'd27;
            5'b01110: yield_of = 8'd30;
            5'b01111: yield_of = 8'd24;
            5'b10000: yield_of = 8'd20;
            5'b10001: yield_of = 8'd12;
            5'b10010: yield_of = 8'd14;
            5'b10011: yield_of = 8'd16;
            5'b10100: yield_of = 8'd14;
            5'b10101: yield_of = 8'd15;
            5'b10110: yield_of = 8'd12;
            5'b10111: yield_of = 8'd13;
            default:  yield_of = 8'd10;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [4:0]          foe_id_q, foe_id_d;
    logic [LVL_W-1:0]    foe_lvl_q, foe_lvl_d;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LVL_W-1:0]    lvl_q, lvl_d;
    logic                level_up_q, level_up_d;
    logic [SLOT_W-1:0]   level_up_slot_q, level_up_slot_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic                slot_ok;
    logic                rd_ok;
    logic [ACC_W-1:0]    commit_acc;
    logic [XP_W-1:0]     commit_xp;

    logic [XP_W-1:0]     xp_mem_q  [NUM_SLOTS];
    logic [LVL_W-1:0]    lvl_mem_q [NUM_SLOTS];

    assign slot_ok = ({1'b0, slot_q} < NUM_SLOTS_L);
    assign rd_ok   = ({1'b0, rd_slot} < NUM_SLOTS_L);

    // At the level cap the remainder can no longer roll over, so it saturates
    // one short of the threshold; below the cap acc is already < XP_THRESH.
    assign commit_acc = ((lvl_q == MAX_L) && (acc_q > SAT_A)) ? SAT_A : acc_q;
    assign commit_xp  = XP_W'(commit_acc);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        foe_id_d        = foe_id_q;
        foe_lvl_d       = foe_lvl_q;
        gain_d          = gain_q;
        acc_d           = acc_q;
        lvl_d           = lvl_q;
        level_up_d      = 1'b0;
        level_up_slot_d = '0;
        done_d          = 1'b0;
        wr_en           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (award_valid) begin
                    slot_d    = award_slot;
                    foe_id_d  = foe_id;
                    foe_lvl_d = foe_level;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                gain_d  = GAIN_W'(yield_of(foe_id_q)) * GAIN_W'(foe_lvl_q);
                state_d = ST_ADD;
            end
            ST_ADD: begin
                acc_d   = slot_ok ? (ACC_W'(xp_mem_q[slot_q]) + ACC_W'(gain_q))
                                  : ACC_W'(gain_q);
                lvl_d   = slot_ok ? lvl_mem_q[slot_q] : INIT_L;
                state_d = ST_LVL;
            end
            ST_LVL: begin
                // One level per cycle so every level-up gets its own pulse.
                if (slot_ok && (acc_q >= THRESH_A) && (lvl_q < MAX_L)) begin
                    acc_d           = acc_q - THRESH_A;
                    lvl_d           = lvl_q + LVL_W'(1);
                    level_up_d      = 1'b1;
                    level_up_slot_d = slot_q;
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                wr_en   = slot_ok;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q         <= ST_IDLE;
            slot_q          <= '0;
            foe_id_q        <= '0;
            foe_lvl_q       <= '0;
            gain_q          <= '0;
            acc_q           <= '0;
            lvl_q           <= '0;
            level_up_q      <= 1'b0;
            level_up_slot_q <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            slot_q          <= slot_d;
            foe_id_q        <= foe_id_d;
            foe_lvl_q       <= foe_lvl_d;
            gain_q          <= gain_d;
            acc_q           <= acc_d;
            lvl_q           <= lvl_d;
            level_up_q      <= level_up_d;
            level_up_slot_q <= level_up_slot_d;
            done_q          <= done_d;
        end
    end

    // NOTE: the slot file is reset because every slot must start at xp=0, INIT_LEVEL.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                xp_mem_q[i]  <= '0;
                lvl_mem_q[i] <= INIT_L;
            end
        end else if (wr_en) begin
            xp_mem_q[slot_q]  <= commit_xp;
            lvl_mem_q[slot_q] <= lvl_q;
        end
    end

    assign award_ready   = (state_q == ST_IDLE);
    assign busy          = ~award_ready;
    assign level_up      = level_up_q;
    assign level_up_slot = level_up_slot_q;
    assign done          = done_q;
    assign rd_xp         = rd_ok ? xp_mem_q[rd_slot]  : '0;
    assign rd_level      = rd_ok ? lvl_mem_q[rd_slot] : '0;

endmodule

// File: tb/tb_xp_award_engine.sv
// -----------------------------------------------------------------------------
// tb_xp_award_engine
// Directed bench for xp_award_engine. Three instances share the request and
// read-select inputs and have separate valids:
//   [0] default parameters
//   [1] XP_THRESH=16, which allows a long level-up chain
//   [2] INIT_LEVEL=15, where every slot starts at the level cap
// -----------------------------------------------------------------------------
module tb_xp_award_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid [3];
    logic [2:0] award_slot = '0;
    logic [4:0] foe_id = '0;
    logic [3:0] foe_level = '0;
    logic [2:0] rd_slot = '0;

    logic       ready   [3];
    logic [7:0] rd_xp   [3];
    logic [3:0] rd_lvl  [3];
    logic       lu      [3];
    logic [2:0] lu_slot [3];
    logic       done    [3];
    logic       busy    [3];

    int n_tests = 0;
    int n_fail  = 0;
    int init_lvl [3] = '{1, 1, 15};

    always #5 clk = ~clk;

    xp_award_engine u_main (
        .Clk(clk), .Reset_n(rst_n), .award_valid(valid[0]), .award_ready(ready[0]),
        .award_slot(award_slot), .foe_id(foe_id), .foe_level(foe_level), .rd_slot(rd_slot),
        .rd_xp(rd_xp[0]), .rd_level(rd_lvl[0]), .level_up(lu[0]), .level_up_slot(lu_slot[0]),
        .done(done[0]), .busy(busy[0])
    );

    xp_award_engine #(.XP_THRESH(16)) u_thr (
        .Clk(clk), .Reset_n(rst_n), .award_valid(valid[1]), .award_ready(ready[1]),
        .award_slot(award_slot), .foe_id(foe_id), .foe_level(foe_level), .rd_slot(rd_slot),
        .rd_xp(rd_xp[1]), .rd_level(rd_lvl[1]), .level_up(lu[1]), .level_up_slot(lu_slot[1]),
        .done(done[1]), .busy(busy[1])
    );

    xp_award_engine #(.INIT_LEVEL(15)) u_cap (
        .Clk(clk), .Reset_n(rst_n), .award_valid(valid[2]), .award_ready(ready[2]),
        .award_slot(award_slot), .foe_id(foe_id), .foe_level(foe_level), .rd_slot(rd_slot),
        .rd_xp(rd_xp[2]), .rd_level(rd_lvl[2]), .level_up(lu[2]), .level_up_slot(lu_slot[2]),
        .done(done[2]), .busy(busy[2])
    );

    // Issues one award to instance k and returns:
    //   lat     cycles from the accept edge to the done cycle
    //   ups     number of level_up pulses seen
    //   old_xp  read-port XP sampled in the write-back cycle
    // The task checks level_up_slot on every pulse and bounds every wait.
    task automatic award(input int k, input logic [2:0] slot, input logic [4:0] foe,
                         input logic [3:0] fl, output int lat, output int ups,
                         output logic [7:0] old_xp);
        int guard;
        @(negedge clk);
        award_slot = slot;
        foe_id     = foe;
        foe_level  = fl;
        rd_slot    = slot;
        valid[k]   = 1'b1;
        guard      = 0;
        while (!ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        valid[k] = 1'b0;
        lat      = 0;
        ups      = 0;
        old_xp   = '0;
        while (!done[k] && lat < 60) begin
            if (lu[k]) begin
                ups++;
                n_tests++;
                if (lu_slot[k] !== slot) begin
                    n_fail++;
                    $display("FAIL lu_slot inst%0d: got %0d want %0d", k, lu_slot[k], slot);
                end
            end
            old_xp = rd_xp[k];
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (!done[k] || !ready[k]) begin
            n_fail++;
            $display("FAIL done_timeout inst%0d: done=%b ready=%b after %0d cycles",
                     k, done[k], ready[k], lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = '{1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ready[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
                lu[k] !== 1'b0 || lu_slot[k] !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_ctrl inst%0d: ready=%b busy=%b done=%b lu=%b lu_slot=%0d",
                         k, ready[k], busy[k], done[k], lu[k], lu_slot[k]);
            end
            for (int s = 0; s < 6; s++) begin
                rd_slot = 3'(s);
                #1;
                n_tests++;
                if (rd_xp[k] !== 8'd0 || rd_lvl[k] !== 4'(init_lvl[k])) begin
                    n_fail++;
                    $display("FAIL reset_slot inst%0d s%0d: xp=%0d L%0d want 0 L%0d",
                             k, s, rd_xp[k], rd_lvl[k], init_lvl[k]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Builds slot0 up to xp=200 L3, then applies a 75-XP award for one level-up.
    task automatic test_single_level_up();
        int lat, ups;
        logic [7:0] old;
        int         exp_lat [4] = '{5, 5, 4, 5};
        int         exp_ups [4] = '{1, 1, 0, 1};
        logic [7:0] exp_xp  [4] = '{8'd194, 8'd188, 8'd200, 8'd19};
        logic [3:0] exp_lv  [4] = '{4'd2, 4'd3, 4'd3, 4'd4};
        logic [4:0] foes    [4] = '{5'b01110, 5'b01100, 5'b10001, 5'b01100};
        logic [3:0] fls     [4] = '{4'd15, 4'd10, 4'd1, 4'd3};
        for (int i = 0; i < 4; i++) begin
            award(0, 3'd0, foes[i], fls[i], lat, ups, old);
            n_tests++;
            if (lat !== exp_lat[i] || ups !== exp_ups[i] ||
                rd_xp[0] !== exp_xp[i] || rd_lvl[0] !== exp_lv[i]) begin
                n_fail++;
                $display("FAIL single_lu step%0d: lat=%0d ups=%0d xp=%0d L%0d want %0d %0d %0d L%0d",
                         i, lat, ups, rd_xp[0], rd_lvl[0], exp_lat[i], exp_ups[i], exp_xp[i], exp_lv[i]);
            end
        end
        n_tests++;
        if (old !== 8'd200) begin
            n_fail++;
            $display("FAIL commit_old_read: got %0d want 200", old);
        end
    endtask

    task automatic test_repeat_award();
        int lat, ups;
        logic [7:0] old;
        award(0, 3'd1, 5'b10101, 4'd13, lat, ups, old);
        n_tests++;
        if (lat !== 4 || ups !== 0 || rd_xp[0] !== 8'd195 || rd_lvl[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL repeat_1: lat=%0d ups=%0d xp=%0d L%0d want 4 0 195 L1",
                     lat, ups, rd_xp[0], rd_lvl[0]);
        end
        award(0, 3'd1, 5'b10101, 4'd13, lat, ups, old);
        n_tests++;
        if (lat !== 5 || ups !== 1 || rd_xp[0] !== 8'd134 || rd_lvl[0] !== 4'd2) begin
            n_fail++;
            $display("FAIL repeat_2: lat=%0d ups=%0d xp=%0d L%0d want 5 1 134 L2",
                     lat, ups, rd_xp[0], rd_lvl[0]);
        end
    endtask

    // With XP_THRESH=16, 250 XP would earn 15 levels; the chain stops at L15 after 14 pulses.
    task automatic test_multi_level_cap();
        int lat, ups;
        logic [7:0] old;
        award(1, 3'd2, 5'b01100, 4'd10, lat, ups, old);
        n_tests++;
        if (lat !== 18 || ups !== 14 || rd_xp[1] !== 8'd15 || rd_lvl[1] !== 4'd15) begin
            n_fail++;
            $display("FAIL multi_lu: lat=%0d ups=%0d xp=%0d L%0d want 18 14 15 L15",
                     lat, ups, rd_xp[1], rd_lvl[1]);
        end
    endtask

    task automatic test_max_level_saturate();
        int lat, ups;
        logic [7:0] old;
        logic [4:0] foes   [3] = '{5'b01100, 5'b01110, 5'b01110};
        logic [3:0] fls    [3] = '{4'd4, 4'd3, 4'd3};
        logic [7:0] exp_xp [3] = '{8'd100, 8'd190, 8'd255};
        for (int i = 0; i < 3; i++) begin
            award(2, 3'd0, foes[i], fls[i], lat, ups, old);
            n_tests++;
            if (lat !== 4 || ups !== 0 || rd_xp[2] !== exp_xp[i] || rd_lvl[2] !== 4'd15) begin
                n_fail++;
                $display("FAIL cap_sat step%0d: lat=%0d ups=%0d xp=%0d L%0d want 4 0 %0d L15",
                         i, lat, ups, rd_xp[2], rd_lvl[2], exp_xp[i]);
            end
        end
    endtask

    task automatic test_edge_cases();
        int lat, ups;
        logic [7:0] old;
        // foe_level 0: the slot is rewritten unchanged.
        award(0, 3'd4, 5'b01100, 4'd0, lat, ups, old);
        n_tests++;
        if (lat !== 4 || ups !== 0 || rd_xp[0] !== 8'd0 || rd_lvl[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL foe_lvl0: lat=%0d ups=%0d xp=%0d L%0d want 4 0 0 L1",
                     lat, ups, rd_xp[0], rd_lvl[0]);
        end
        // An unlisted species id yields 10 per foe level.
        award(0, 3'd5, 5'b00011, 4'd7, lat, ups, old);
        n_tests++;
        if (lat !== 4 || ups !== 0 || rd_xp[0] !== 8'd70 || rd_lvl[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL default_yield: lat=%0d ups=%0d xp=%0d L%0d want 4 0 70 L1",
                     lat, ups, rd_xp[0], rd_lvl[0]);
        end
        // An out-of-range slot completes, pulses nothing else and writes nothing.
        award(0, 3'd6, 5'b01110, 4'd15, lat, ups, old);
        n_tests++;
        if (lat !== 4 || ups !== 0) begin
            n_fail++;
            $display("FAIL bad_slot: lat=%0d ups=%0d want 4 0", lat, ups);
        end
        rd_slot = 3'd0;
        #1;
        n_tests++;
        if (rd_xp[0] !== 8'd19 || rd_lvl[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL bad_slot_side: slot0 xp=%0d L%0d want 19 L4", rd_xp[0], rd_lvl[0]);
        end
    endtask

    // The second request waits with valid held high and is accepted in the done cycle.
    task automatic test_back_to_back();
        int c;
        int guard;
        @(negedge clk);
        award_slot = 3'd2;
        foe_id     = 5'b10000;
        foe_level  = 4'd5;
        valid[0]   = 1'b1;
        guard      = 0;
        while (!ready[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        award_slot = 3'd3;
        foe_id     = 5'b01101;
        foe_level  = 4'd10;
        c = 0;
        while (!done[0] && c < 60) begin
            n_tests++;
            if (ready[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_holdoff: ready=%b at busy cycle %0d", ready[0], c);
            end
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (c !== 4 || done[0] !== 1'b1 || ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d done=%b ready=%b want 4 1 1", c, done[0], ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        c = 0;
        while (!done[0] && c < 60) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (c !== 5 || done[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d done=%b want 5 1", c, done[0]);
        end
        rd_slot = 3'd2;
        #1;
        n_tests++;
        if (rd_xp[0] !== 8'd100 || rd_lvl[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL b2b_slot2: xp=%0d L%0d want 100 L1", rd_xp[0], rd_lvl[0]);
        end
        rd_slot = 3'd3;
        #1;
        n_tests++;
        if (rd_xp[0] !== 8'd14 || rd_lvl[0] !== 4'd2) begin
            n_fail++;
            $display("FAIL b2b_slot3: xp=%0d L%0d want 14 L2", rd_xp[0], rd_lvl[0]);
        end
    endtask

    // Reset lands while the engine sits in LVL with a level-up pending.
    task automatic test_reset_mid_award();
        int guard;
        int seen;
        @(negedge clk);
        award_slot = 3'd3;
        foe_id     = 5'b01110;
        foe_level  = 4'd15;
        rd_slot    = 3'd3;
        valid[0]   = 1'b1;
        guard      = 0;
        while (!ready[0] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ready[0] !== 1'b1 || lu[0] !== 1'b0 || done[0] !== 1'b0 ||
            rd_xp[0] !== 8'd0 || rd_lvl[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b lu=%b done=%b xp=%0d L%0d want 1 0 0 0 L1",
                     ready[0], lu[0], done[0], rd_xp[0], rd_lvl[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done[0] || lu[0]) seen++;
        end
        n_tests++;
        if (seen !== 0 || rd_xp[0] !== 8'd0 || rd_lvl[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL mid_reset_after: pulses=%0d xp=%0d L%0d want 0 0 L1",
                     seen, rd_xp[0], rd_lvl[0]);
        end
    endtask

    initial begin
        valid = '{1'b0, 1'b0, 1'b0};
        test_reset();
        test_single_level_up();
        test_repeat_award();
        test_multi_level_cap();
        test_max_level_saturate();
        test_edge_cases();
        test_back_to_back();
        test_reset_mid_award();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
